// File: rtl/branch_resolve_queue_pkg.sv
// Shared definitions for the correlating branch predictor and its resolve queue.
// Holds the 2-bit counter encodings and the counter next-state function used both
// by the predictor and by the resolve path. Queue entries are {addr, hist, state,
// taken}; the address field is sized by the consumer's ADDR_W, so the entry struct
// itself lives in the consuming module.
package branch_resolve_queue_pkg;

  localparam logic [1:0] ST_SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] ST_WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] ST_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] ST_ST  = 2'b11;  // strongly taken

  // Any not-taken outcome from a non-strong state drops straight to ST_SNT, and a
  // taken outcome from either weak state jumps to ST_ST.
  function automatic logic [1:0] sat_next(input logic [1:0] state, input logic taken);
    logic [1:0] nxt;
    case (state)
      ST_SNT:  nxt = taken ? ST_WNT : ST_SNT;
      ST_WNT:  nxt = taken ? ST_ST  : ST_SNT;
      ST_WT:   nxt = taken ? ST_ST  : ST_SNT;
      default: nxt = taken ? ST_ST  : ST_WT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_queue_next.sv
// sat_counter_next: combinational 2-bit counter next-state.
//   state_i : current counter value
//   taken_i : resolved branch outcome
//   next_o  : counter value to write back
module sat_counter_next
  import branch_resolve_queue_pkg::*;
(
  input  logic [1:0] state_i,
  input  logic       taken_i,
  output logic [1:0] next_o
);

  assign next_o = sat_next(state_i, taken_i);

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of in-flight branch predictions.
// Each resolve pops the head, produces a registered BHT write-back, mispredict
// pulse and committed history bit, and bumps saturating statistics counters.
//   pred_*     : prediction push interface (pred_ready = !full)
//   res_*      : resolution of the oldest in-flight branch
//   upd_*      : BHT write-back, valid for one cycle after a resolve
//   hist_out   : committed global history bit
//   mispredict : one-cycle flush pulse
//   occupancy  : entries held
//   br_count   : resolved branches, mp_count : mispredicts (both saturating)
//   res_err    : sticky, a resolve arrived while the queue was empty
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic [ADDR_W-1:0]        pred_addr,
  input  logic                     pred_hist,
  input  logic [1:0]               pred_state,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     upd_we,
  output logic                     upd_sel,
  output logic [ADDR_W-1:0]        upd_addr,
  output logic [1:0]               upd_data,
  output logic                     hist_out,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         br_count,
  output logic [CNT_W-1:0]         mp_count,
  output logic                     res_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              hist;
    logic [1:0]        state;
    logic              taken;
  } entry_t;

  entry_t            entries_q [DEPTH];
  entry_t            entries_d [DEPTH];
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [OccW-1:0]   occ_q, occ_d;
  logic              upd_we_q, upd_we_d, upd_sel_q, upd_sel_d;
  logic [ADDR_W-1:0] upd_addr_q, upd_addr_d;
  logic [1:0]        upd_data_q, upd_data_d;
  logic              hist_q, hist_d, mp_q, mp_d, res_err_q, res_err_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;

  logic       full, empty, do_res, flush, do_push, head_fwd, push_fwd;
  logic [1:0] head_state, next_state;
  entry_t     head;

  assign full  = (occ_q == OccW'(DEPTH));
  assign empty = (occ_q == '0);
  assign head  = entries_q[head_q];

  // The write-back of the previous resolve lands in the array only at the end of
  // this cycle, so a back-to-back resolve of an aliased head must see it here.
  assign head_fwd   = upd_we_q && (head.addr == upd_addr_q) && (head.hist == upd_sel_q);
  assign head_state = head_fwd ? upd_data_q : head.state;
  assign push_fwd   = upd_we_q && (pred_addr == upd_addr_q) && (pred_hist == upd_sel_q);

  assign do_res  = res_valid && !empty;
  assign flush   = do_res && (head.taken != res_taken);
  // A push alongside a mispredict is on the wrong path and is dropped.
  assign do_push = pred_valid && !full && !flush;

  sat_counter_next u_next (
    .state_i (head_state),
    .taken_i (res_taken),
    .next_o  (next_state)
  );

  always_comb begin
    entries_d = entries_q;
    if (upd_we_q) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (entries_q[i].addr == upd_addr_q && entries_q[i].hist == upd_sel_q) begin
          entries_d[i].state = upd_data_q;
        end
      end
    end
    if (do_push) begin
      entries_d[tail_q].addr  = pred_addr;
      entries_d[tail_q].hist  = pred_hist;
      entries_d[tail_q].state = push_fwd ? upd_data_q : pred_state;
      entries_d[tail_q].taken = pred_taken;
    end

    if (flush) begin
      head_d = head_q + PtrW'(1);
      tail_d = head_q + PtrW'(1);
      occ_d  = '0;
    end else begin
      head_d = head_q + PtrW'(do_res);
      tail_d = tail_q + PtrW'(do_push);
      occ_d  = occ_q + OccW'(do_push) - OccW'(do_res);
    end

    upd_we_d   = do_res;
    upd_sel_d  = do_res ? head.hist : upd_sel_q;
    upd_addr_d = do_res ? head.addr : upd_addr_q;
    upd_data_d = do_res ? next_state : upd_data_q;
    hist_d     = do_res ? res_taken : hist_q;
    mp_d       = flush;
    br_cnt_d   = (do_res && br_cnt_q != '1) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
    mp_cnt_d   = (flush && mp_cnt_q != '1) ? mp_cnt_q + CNT_W'(1) : mp_cnt_q;
    res_err_d  = res_err_q | (res_valid && empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      upd_we_q   <= 1'b0;
      upd_sel_q  <= 1'b0;
      upd_addr_q <= '0;
      upd_data_q <= '0;
      hist_q     <= 1'b0;
      mp_q       <= 1'b0;
      br_cnt_q   <= '0;
      mp_cnt_q   <= '0;
      res_err_q  <= 1'b0;
    end else begin
      entries_q  <= entries_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      upd_we_q   <= upd_we_d;
      upd_sel_q  <= upd_sel_d;
      upd_addr_q <= upd_addr_d;
      upd_data_q <= upd_data_d;
      hist_q     <= hist_d;
      mp_q       <= mp_d;
      br_cnt_q   <= br_cnt_d;
      mp_cnt_q   <= mp_cnt_d;
      res_err_q  <= res_err_d;
    end
  end

  assign pred_ready = !full;
  assign upd_we     = upd_we_q;
  assign upd_sel    = upd_sel_q;
  assign upd_addr   = upd_addr_q;
  assign upd_data   = upd_data_q;
  assign hist_out   = hist_q;
  assign mispredict = mp_q;
  assign occupancy  = occ_q;
  assign br_count   = br_cnt_q;
  assign mp_count   = mp_cnt_q;
  assign res_err    = res_err_q;

endmodule
